// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped GPIO, timer and TX FIFO block decoded at 0xFF00-0xFF0F.
// Loads answer with a one-cycle strobe two cycles after the request. Stores complete in one cycle.

module mmio_responder (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  input  logic        req_wren,
  input  logic        req_rden,
  output logic [15:0] rsp_rdata,
  output logic        rsp_valid,
  input  logic [15:0] gpio_in,
  output logic [15:0] gpio_out,
  output logic [15:0] fifo_out_data,
  output logic        fifo_out_valid,
  input  logic        fifo_out_ready,
  output logic        timer_irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD1  = 2'd1,
    RD2  = 2'd2
  } rd_state_t;

  rd_state_t   r_state;
  rd_state_t   w_state_nxt;
  logic        w_capture;
  logic        w_strobe;

  logic [15:0] r_raddr;
  logic [15:0] r_rdata;
  logic        r_valid;

  logic [15:0] r_gpio_out;
  logic [15:0] r_sync1;
  logic [15:0] r_sync2;
  logic [15:0] r_cnt;
  logic [15:0] r_cmp;
  logic        r_irq;
  logic        r_ovf;

  logic [15:0] r_mem [4];
  logic [1:0]  r_wptr;
  logic [1:0]  r_rptr;
  logic [2:0]  r_count;

  logic        w_idle;
  logic        w_wr;
  logic        w_rd_start;
  logic        w_hit;
  logic        w_we_gpio;
  logic        w_we_cnt;
  logic        w_we_cmp;
  logic        w_we_fifo;
  logic        w_we_clr;
  logic        w_full;
  logic        w_empty;
  logic        w_pop;
  logic        w_push;
  logic        w_drop;
  logic        w_wrap;
  logic [15:0] w_status;
  logic [15:0] w_rmux;
  logic [2:0]  w_count_nxt;

  // Requests are only accepted in IDLE; a store beats a simultaneous load.
  assign w_idle     = (r_state == IDLE);
  assign w_wr       = w_idle & req_wren;
  assign w_rd_start = w_idle & req_rden & ~req_wren;
  assign w_hit      = (req_addr[15:4] == 12'hFF0);

  // Store address decode
  always_comb begin
    w_we_gpio = 1'b0;
    w_we_cnt  = 1'b0;
    w_we_cmp  = 1'b0;
    w_we_fifo = 1'b0;
    w_we_clr  = 1'b0;
    if (w_wr && w_hit) begin
      case (req_addr[3:0])
        4'h0:    w_we_gpio = 1'b1;
        4'h2:    w_we_cnt  = 1'b1;
        4'h3:    w_we_cmp  = 1'b1;
        4'h5:    w_we_fifo = 1'b1;
        4'h6:    w_we_clr  = 1'b1;
        default: w_we_gpio = 1'b0;
      endcase
    end else begin
      w_we_gpio = 1'b0;
    end
  end

  // Read FSM next-state and control strobes
  always_comb begin
    w_state_nxt = r_state;
    w_capture   = 1'b0;
    w_strobe    = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_rd_start) begin
          w_state_nxt = RD1;
        end else begin
          w_state_nxt = IDLE;
        end
      end
      RD1: begin
        w_state_nxt = RD2;
        w_capture   = 1'b1;
      end
      RD2: begin
        w_state_nxt = IDLE;
        w_strobe    = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign w_full   = (r_count == 3'd4);
  assign w_empty  = (r_count == 3'd0);
  assign w_status = {9'd0, r_ovf, r_count, w_empty, w_full, r_irq};

  // Load data mux on the latched address
  always_comb begin
    w_rmux = 16'h0000;
    if (r_raddr[15:4] == 12'hFF0) begin
      case (r_raddr[3:0])
        4'h0:    w_rmux = r_gpio_out;
        4'h1:    w_rmux = r_sync2;
        4'h2:    w_rmux = r_cnt;
        4'h3:    w_rmux = r_cmp;
        4'h4:    w_rmux = w_status;
        default: w_rmux = 16'h0000;
      endcase
    end else begin
      w_rmux = 16'h0000;
    end
  end

  // Read FSM state, latched address and response registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= IDLE;
      r_raddr <= 16'h0000;
      r_rdata <= 16'h0000;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_valid <= w_strobe;
      if (w_rd_start) begin
        r_raddr <= req_addr;
      end
      if (w_capture) begin
        r_rdata <= w_rmux;
      end
    end
  end

  // A CPU write to the counter suppresses the wrap and its interrupt.
  assign w_wrap = (r_cnt == r_cmp) & ~w_we_cnt;

  // GPIO, input synchronizer, timer and sticky interrupt state
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_gpio_out <= 16'h0000;
      r_sync1    <= 16'h0000;
      r_sync2    <= 16'h0000;
      r_cnt      <= 16'h0000;
      r_cmp      <= 16'h0000;
      r_irq      <= 1'b0;
    end else begin
      r_sync1 <= gpio_in;
      r_sync2 <= r_sync1;
      if (w_we_gpio) begin
        r_gpio_out <= req_wdata;
      end
      if (w_we_cmp) begin
        r_cmp <= req_wdata;
      end
      if (w_we_cnt) begin
        r_cnt <= req_wdata;
      end else if (w_wrap) begin
        r_cnt <= 16'h0000;
      end else begin
        r_cnt <= r_cnt + 16'd1;
      end
      if (w_wrap) begin
        r_irq <= 1'b1;
      end else if (w_we_clr) begin
        r_irq <= 1'b0;
      end
    end
  end

  // A push into a full FIFO only lands if a pop frees the slot in the same cycle.
  assign w_pop  = ~w_empty & fifo_out_ready;
  assign w_push = w_we_fifo & (~w_full | w_pop);
  assign w_drop = w_we_fifo & w_full & ~w_pop;

  // FIFO occupancy update
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 3'd1;
      2'b01:   w_count_nxt = r_count - 3'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // FIFO storage, pointers, count and overflow flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < 4; i++) begin
        r_mem[i] <= 16'h0000;
      end
      r_wptr  <= 2'd0;
      r_rptr  <= 2'd0;
      r_count <= 3'd0;
      r_ovf   <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      if (w_push) begin
        r_mem[r_wptr] <= req_wdata;
        r_wptr        <= r_wptr + 2'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
      end
      if (w_drop) begin
        r_ovf <= 1'b1;
      end else if (w_we_clr) begin
        r_ovf <= 1'b0;
      end
    end
  end

  assign rsp_rdata      = r_rdata;
  assign rsp_valid      = r_valid;
  assign gpio_out       = r_gpio_out;
  assign fifo_out_data  = r_mem[r_rptr];
  assign fifo_out_valid = ~w_empty;
  assign timer_irq      = r_irq;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder: directed scenarios plus randomized traffic,
// all checked every cycle against a transaction-level reference model.

module tb_mmio_responder;

  logic        clk;
  logic        reset;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        req_wren;
  logic        req_rden;
  logic [15:0] rsp_rdata;
  logic        rsp_valid;
  logic [15:0] gpio_in;
  logic [15:0] gpio_out;
  logic [15:0] fifo_out_data;
  logic        fifo_out_valid;
  logic        fifo_out_ready;
  logic        timer_irq;

  mmio_responder dut (
    .clk            (clk),
    .reset          (reset),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .req_wren       (req_wren),
    .req_rden       (req_rden),
    .rsp_rdata      (rsp_rdata),
    .rsp_valid      (rsp_valid),
    .gpio_in        (gpio_in),
    .gpio_out       (gpio_out),
    .fifo_out_data  (fifo_out_data),
    .fifo_out_valid (fifo_out_valid),
    .fifo_out_ready (fifo_out_ready),
    .timer_irq      (timer_irq)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_total = 0;
  int n_bad   = 0;

  // Reference model: registers as plain variables, FIFO as a queue,
  // a pending load as a countdown of cycles until its data is taken.
  logic [15:0] m_gpio_out = 16'h0000;
  logic [15:0] m_sync1    = 16'h0000;
  logic [15:0] m_sync2    = 16'h0000;
  logic [15:0] m_cnt      = 16'h0000;
  logic [15:0] m_cmp      = 16'h0000;
  logic        m_irq      = 1'b0;
  logic        m_ovf      = 1'b0;
  logic [15:0] m_q[$];
  int          m_busy     = 0;
  logic [15:0] m_raddr    = 16'h0000;
  logic [15:0] m_rdata    = 16'h0000;
  logic        m_valid    = 1'b0;
  logic [15:0] g_gin      = 16'h0000;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h expected=%h at t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_read(input logic [15:0] a);
    logic [15:0] st;
    int n;
    n  = m_q.size();
    st = 16'h0000;
    st[0]   = m_irq;
    st[1]   = (n == 4);
    st[2]   = (n == 0);
    st[5:3] = n[2:0];
    st[6]   = m_ovf;
    if (a < 16'hFF00 || a > 16'hFF0F) return 16'h0000;
    case (a - 16'hFF00)
      16'd0:   return m_gpio_out;
      16'd1:   return m_sync2;
      16'd2:   return m_cnt;
      16'd3:   return m_cmp;
      16'd4:   return st;
      default: return 16'h0000;
    endcase
  endfunction

  task automatic m_step();
    logic        accept;
    logic        wr;
    logic        rd;
    logic        hit;
    logic [15:0] off;
    logic        pop;
    logic        was_full;
    logic        wrap;
    logic        clr;
    if (!reset) begin
      m_gpio_out = 16'h0000; m_sync1 = 16'h0000; m_sync2 = 16'h0000;
      m_cnt = 16'h0000; m_cmp = 16'h0000; m_irq = 1'b0; m_ovf = 1'b0;
      m_q.delete(); m_busy = 0; m_rdata = 16'h0000; m_valid = 1'b0;
    end else begin
      accept = (m_busy == 0);
      wr  = accept && req_wren;
      rd  = accept && req_rden && !req_wren;
      hit = (req_addr >= 16'hFF00) && (req_addr <= 16'hFF0F);
      off = req_addr - 16'hFF00;
      // load data is sampled from state before this edge's updates
      if (m_busy == 2) m_rdata = m_read(m_raddr);
      m_valid = (m_busy == 1);
      if (rd) begin
        m_busy  = 2;
        m_raddr = req_addr;
      end else if (m_busy > 0) begin
        m_busy--;
      end
      wrap     = !(wr && hit && off == 16'd2) && (m_cnt == m_cmp);
      clr      = wr && hit && off == 16'd6;
      pop      = (m_q.size() > 0) && fifo_out_ready;
      was_full = (m_q.size() == 4);
      m_sync2 = m_sync1;
      m_sync1 = gpio_in;
      if (wr && hit && off == 16'd0) m_gpio_out = req_wdata;
      if (wr && hit && off == 16'd3) m_cmp = req_wdata;
      if (wr && hit && off == 16'd2) m_cnt = req_wdata;
      else if (wrap) m_cnt = 16'h0000;
      else m_cnt = m_cnt + 16'd1;
      if (wrap) m_irq = 1'b1;
      else if (clr) m_irq = 1'b0;
      if (pop) void'(m_q.pop_front());
      if (wr && hit && off == 16'd5) begin
        if (!was_full || pop) m_q.push_back(req_wdata);
        else m_ovf = 1'b1;
      end else if (clr) begin
        m_ovf = 1'b0;
      end
    end
  endtask

  task automatic check_outputs();
    chk("rsp_valid", {15'd0, rsp_valid}, {15'd0, m_valid});
    chk("rsp_rdata", rsp_rdata, m_rdata);
    chk("gpio_out", gpio_out, m_gpio_out);
    chk("timer_irq", {15'd0, timer_irq}, {15'd0, m_irq});
    chk("fifo_valid", {15'd0, fifo_out_valid}, {15'd0, (m_q.size() > 0)});
    if (m_q.size() > 0) chk("fifo_data", fifo_out_data, m_q[0]);
  endtask

  // Drive one cycle of inputs, advance model and DUT, compare after the edge.
  task automatic step(input logic rst, input logic [15:0] a, input logic [15:0] w,
                      input logic we, input logic re, input logic rdy);
    reset = rst; req_addr = a; req_wdata = w; req_wren = we; req_rden = re;
    fifo_out_ready = rdy; gpio_in = g_gin;
    @(posedge clk);
    m_step();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic wr(input logic [15:0] a, input logic [15:0] w);
    step(1'b1, a, w, 1'b1, 1'b0, 1'b0);
  endtask

  // Issue a load and stop in the cycle where its strobe should be visible.
  task automatic rd(input logic [15:0] a);
    step(1'b1, a, 16'h0000, 1'b0, 1'b1, 1'b0);
    idle(2);
  endtask

  int nstb;

  initial begin
    g_gin = 16'h5A5A;
    reset = 1'b0; req_addr = 16'h0000; req_wdata = 16'h0000;
    req_wren = 1'b0; req_rden = 1'b0; fifo_out_ready = 1'b0; gpio_in = g_gin;

    // reset with requests present
    step(1'b0, 16'hFF00, 16'hFFFF, 1'b1, 1'b0, 1'b0);
    step(1'b0, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b0);
    chk("rst_rsp_valid", {15'd0, rsp_valid}, 16'h0000);
    chk("rst_rdata", rsp_rdata, 16'h0000);
    chk("rst_gpio_out", gpio_out, 16'h0000);
    chk("rst_fifo_valid", {15'd0, fifo_out_valid}, 16'h0000);
    chk("rst_irq", {15'd0, timer_irq}, 16'h0000);

    // quiet the timer so directed status reads are deterministic
    wr(16'hFF03, 16'hFFFF);
    wr(16'hFF06, 16'h0000);

    // store then load GPIO_OUT
    wr(16'hFF00, 16'h1234);
    chk("gpio_after_write", gpio_out, 16'h1234);
    rd(16'hFF00);
    chk("gpio_rd_valid", {15'd0, rsp_valid}, 16'h0001);
    chk("gpio_rd_data", rsp_rdata, 16'h1234);
    idle(1);
    chk("gpio_rd_single", {15'd0, rsp_valid}, 16'h0000);

    // timer wrap and interrupt clear, including clear colliding with a wrap
    wr(16'hFF03, 16'h0003);
    wr(16'hFF02, 16'h0000);
    idle(3);
    chk("irq_before_wrap", {15'd0, timer_irq}, 16'h0000);
    idle(1);
    chk("irq_on_wrap", {15'd0, timer_irq}, 16'h0001);
    wr(16'hFF06, 16'h0000);
    chk("irq_cleared", {15'd0, timer_irq}, 16'h0000);
    idle(2);
    wr(16'hFF06, 16'h0000);
    chk("irq_set_wins", {15'd0, timer_irq}, 16'h0001);
    wr(16'hFF03, 16'hFFFF);
    wr(16'hFF06, 16'h0000);

    // overfill the FIFO, check status, then drain in order
    for (int i = 0; i < 5; i++) wr(16'hFF05, 16'h00A0 + 16'(i));
    rd(16'hFF04);
    chk("status_full_ovf", rsp_rdata, 16'h0062);
    for (int i = 0; i < 4; i++) begin
      chk("fifo_order", fifo_out_data, 16'h00A0 + 16'(i));
      step(1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b1);
    end
    chk("fifo_drained", {15'd0, fifo_out_valid}, 16'h0000);
    wr(16'hFF06, 16'h0000);

    // simultaneous store and load: store wins, no strobe
    nstb = 0;
    step(1'b1, 16'hFF00, 16'h00FF, 1'b1, 1'b1, 1'b0);
    chk("dual_write", gpio_out, 16'h00FF);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (rsp_valid) nstb++;
    end
    chk("dual_no_strobe", 16'(nstb), 16'h0000);

    // a load issued during RD1 is ignored
    nstb = 0;
    step(1'b1, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b1, 16'hFF03, 16'h0000, 1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) begin
      idle(1);
      if (rsp_valid) nstb++;
    end
    chk("one_strobe", 16'(nstb), 16'h0001);

    // reset in RD1 aborts the load
    nstb = 0;
    step(1'b1, 16'hFF00, 16'h0000, 1'b0, 1'b1, 1'b0);
    step(1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
    chk("abort_gpio", gpio_out, 16'h0000);
    chk("abort_rdata", rsp_rdata, 16'h0000);
    chk("abort_fifo", {15'd0, fifo_out_valid}, 16'h0000);
    chk("abort_irq", {15'd0, timer_irq}, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      idle(1);
      if (rsp_valid) nstb++;
    end
    chk("abort_no_strobe", 16'(nstb), 16'h0000);
    rd(16'hFF04);
    // bit0 is left to the model: CNT==CMP==0 after reset raises the interrupt
    chk("post_rst_status", rsp_rdata & 16'hFFFE, 16'h0004);

    // out-of-window address
    rd(16'h1000);
    chk("miss_valid", {15'd0, rsp_valid}, 16'h0001);
    chk("miss_data", rsp_rdata, 16'h0000);
    wr(16'h1000, 16'hFFFF);
    chk("miss_no_write", gpio_out, 16'h0000);
    rd(16'hFF00);
    chk("miss_gpio_rd", rsp_rdata, 16'h0000);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] a;
      logic [15:0] w;
      logic        rst;
      if ($urandom_range(0, 7) == 0) a = 16'($urandom);
      else a = 16'hFF00 + 16'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 0) w = 16'($urandom_range(0, 15));
      else w = 16'($urandom);
      rst = ($urandom_range(0, 199) != 0);
      if ($urandom_range(0, 3) == 0) g_gin = 16'($urandom);
      step(rst, a, w, ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
           ($urandom_range(0, 1) == 0));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
